pci_cfg_space: RTL and testbench

PCI_CFG_SPACE -- requirements
Module: pci_cfg_space

---
 rtl/pci_pkg.sv | 49 ++++
 rtl/pci_cfg_space.sv | 191 +++++++++++++++++++
 tb/tb_pci_cfg_space.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI configuration space block: register offsets,
// Command bit positions, access FSM states and the byte-lane write merge.
package pci_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } cfg_state_e;

  localparam logic [5:0] OFF_ID        = 6'd0;
  localparam logic [5:0] OFF_CMD_STS   = 6'd1;
  localparam logic [5:0] OFF_CLASS_REV = 6'd2;
  localparam logic [5:0] OFF_MISC      = 6'd3;
  localparam logic [5:0] OFF_BAR0      = 6'd4;
  localparam logic [5:0] OFF_SUBSYS    = 6'd11;
  localparam logic [5:0] OFF_CAP_PTR   = 6'd13;
  localparam logic [5:0] OFF_INT       = 6'd15;
  localparam logic [5:0] OFF_MSI_CTRL  = 6'd16;
  localparam logic [5:0] OFF_MSI_ADDR  = 6'd17;
  localparam logic [5:0] OFF_MSI_DATA  = 6'd18;

  localparam int CMD_MEM_EN   = 1;
  localparam int CMD_BM_EN    = 2;
  localparam int CMD_PERR_RSP = 6;
  localparam int CMD_SERR_EN  = 8;
  localparam int CMD_INT_DIS  = 10;

  localparam logic [15:0] CMD_RW_MASK = 16'h0546;

  // Replace bits of old_val with new_val only where the byte lane is enabled
  // (active-low be) and the bit is writable.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be,
                                           input logic [31:0] wmask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (!be[b]) begin
        for (int i = 0; i < 8; i++) begin
          if (wmask[8*b+i]) res[8*b+i] = new_val[8*b+i];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pci_cfg_space.sv
// PCI type-0 configuration space: ID/class registers, Command/Status,
// BAR0, interrupt line and an optional MSI capability (PCI_CFG_MSI_EN).
// Accesses run through a three-state handshake FSM; register mirrors are
// driven straight from the storage flops.
module pci_cfg_space
  import pci_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID      = 16'h1234,
  parameter logic [15:0] DEVICE_ID      = 16'h11E8,
  parameter logic [31:0] CLASS_REV      = 32'h00FF0010,
  parameter int          BAR0_SIZE_LOG2 = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_enable,
  input  logic        cfg_iswrite,
  input  logic [5:0]  cfg_offset,
  input  logic [31:0] cfg_write_val,
  input  logic [3:0]  cfg_be,
  output logic [31:0] cfg_read_val,
  output logic        cfg_done,
  output logic        cfg_w_err,
  input  logic        parity_error_detected,
  output logic        parity_error_response_reg,
  output logic        serr_enable_reg,
  output logic        mem_space_en,
  output logic        bus_master_en,
  output logic        int_disable,
  output logic [31:0] bar0_base,
  output logic        msi_enable,
  output logic [31:0] msi_addr,
  output logic [15:0] msi_data
);

`ifdef PCI_CFG_MSI_EN
  localparam bit MSI_ON = 1'b1;
`else
  localparam bit MSI_ON = 1'b0;
`endif

  localparam logic [31:0] BAR0_MASK = ~((32'd1 << BAR0_SIZE_LOG2) - 32'd1);

  cfg_state_e  state;
  logic        req_iswrite_p0;
  logic [5:0]  req_offset_p0;
  logic [3:0]  req_be_p0;
  logic [31:0] req_wval_p0;

  logic [15:0] cmd_q;
  logic        perr_q;
  logic [7:0]  cls_q;
  logic [7:0]  lat_q;
  logic [31:0] bar0_q;
  logic [7:0]  int_line_q;
  logic        msi_en_q;
  logic [31:0] msi_addr_q;
  logic [15:0] msi_data_q;

  logic [31:0] wmask;
  logic [31:0] rd_val;
  logic [31:0] merged;
  logic        wr_err;
  logic        do_write;
  logic        w1c_hit;

  // Writable-bit mask of the latched offset; zero means the offset is read-only.
  always_comb begin
    wmask = 32'h0;
    case (req_offset_p0)
      OFF_CMD_STS:  wmask = {16'h8000, CMD_RW_MASK};
      OFF_MISC:     wmask = 32'h0000_FFFF;
      OFF_BAR0:     wmask = BAR0_MASK;
      OFF_INT:      wmask = 32'h0000_00FF;
      OFF_MSI_CTRL: wmask = MSI_ON ? 32'h0001_0000 : 32'h0;
      OFF_MSI_ADDR: wmask = MSI_ON ? 32'hFFFF_FFFC : 32'h0;
      OFF_MSI_DATA: wmask = MSI_ON ? 32'h0000_FFFF : 32'h0;
      default:      wmask = 32'h0;
    endcase
  end

  // Read mux over the latched offset; unmapped offsets return zero.
  always_comb begin
    rd_val = 32'h0;
    case (req_offset_p0)
      OFF_ID, OFF_SUBSYS: rd_val = {DEVICE_ID, VENDOR_ID};
      OFF_CMD_STS:        rd_val = {perr_q, 10'd0, MSI_ON, 4'd0, cmd_q};
      OFF_CLASS_REV:      rd_val = CLASS_REV;
      OFF_MISC:           rd_val = {16'h0, lat_q, cls_q};
      OFF_BAR0:           rd_val = bar0_q;
      OFF_CAP_PTR:        rd_val = {24'h0, (MSI_ON ? 8'h40 : 8'h00)};
      OFF_INT:            rd_val = {16'h0, 8'h01, int_line_q};
      OFF_MSI_CTRL:       rd_val = MSI_ON ? {15'h0, msi_en_q, 8'h00, 8'h05} : 32'h0;
      OFF_MSI_ADDR:       rd_val = MSI_ON ? msi_addr_q : 32'h0;
      OFF_MSI_DATA:       rd_val = MSI_ON ? {16'h0, msi_data_q} : 32'h0;
      default:            rd_val = 32'h0;
    endcase
  end

  assign wr_err   = req_iswrite_p0 && (wmask == 32'h0) && (req_be_p0 != 4'hF);
  assign do_write = (state == ACCESS) && req_iswrite_p0 && !wr_err;
  assign merged   = be_merge(rd_val, req_wval_p0, req_be_p0, wmask);
  assign w1c_hit  = do_write && (req_offset_p0 == OFF_CMD_STS) &&
                    !req_be_p0[3] && req_wval_p0[31];

  // Access handshake: latch request, service it, hold done until enable drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      req_iswrite_p0 <= 1'b0;
      req_offset_p0  <= 6'd0;
      req_be_p0      <= 4'hF;
      req_wval_p0    <= 32'h0;
      cfg_done       <= 1'b0;
      cfg_read_val   <= 32'h0;
      cfg_w_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_enable) begin
            req_iswrite_p0 <= cfg_iswrite;
            req_offset_p0  <= cfg_offset;
            req_be_p0      <= cfg_be;
            req_wval_p0    <= cfg_write_val;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          cfg_done     <= 1'b1;
          cfg_read_val <= req_iswrite_p0 ? 32'h0 : rd_val;
          cfg_w_err    <= wr_err;
          state        <= HOLD;
        end
        HOLD: begin
          if (!cfg_enable) begin
            cfg_done     <= 1'b0;
            cfg_read_val <= 32'h0;
            cfg_w_err    <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writable register storage, updated on the ACCESS edge of an accepted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q      <= 16'h0;
      cls_q      <= 8'h0;
      lat_q      <= 8'h0;
      bar0_q     <= 32'h0;
      int_line_q <= 8'h0;
      msi_en_q   <= 1'b0;
      msi_addr_q <= 32'h0;
      msi_data_q <= 16'h0;
    end else if (do_write) begin
      case (req_offset_p0)
        OFF_CMD_STS:  cmd_q <= merged[15:0];
        OFF_MISC: begin
          cls_q <= merged[7:0];
          lat_q <= merged[15:8];
        end
        OFF_BAR0:     bar0_q     <= merged;
        OFF_INT:      int_line_q <= merged[7:0];
        OFF_MSI_CTRL: msi_en_q   <= merged[16];
        OFF_MSI_ADDR: msi_addr_q <= merged;
        OFF_MSI_DATA: msi_data_q <= merged[15:0];
        default: ;
      endcase
    end
  end

  // Detected-parity-error status: a new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       perr_q <= 1'b0;
    else if (parity_error_detected) perr_q <= 1'b1;
    else if (w1c_hit)               perr_q <= 1'b0;
  end

  assign mem_space_en              = cmd_q[CMD_MEM_EN];
  assign bus_master_en             = cmd_q[CMD_BM_EN];
  assign parity_error_response_reg = cmd_q[CMD_PERR_RSP];
  assign serr_enable_reg           = cmd_q[CMD_SERR_EN];
  assign int_disable               = cmd_q[CMD_INT_DIS];
  assign bar0_base                 = bar0_q;
  assign msi_enable                = MSI_ON ? msi_en_q : 1'b0;
  assign msi_addr                  = MSI_ON ? msi_addr_q : 32'h0;
  assign msi_data                  = MSI_ON ? msi_data_q : 16'h0;

endmodule

// File: tb/tb_pci_cfg_space.sv
// Scoreboard bench for pci_cfg_space: stimulus pushes expected responses,
// a monitor pops them whenever cfg_done rises and rechecks while it holds.
module tb_pci_cfg_space;

  localparam logic [15:0] VEN   = 16'h1234;
  localparam logic [15:0] DEV   = 16'h11E8;
  localparam logic [31:0] CLS   = 32'h00FF0010;
  localparam int          BAR_L = 20;
`ifdef PCI_CFG_MSI_EN
  localparam bit MSI = 1'b1;
`else
  localparam bit MSI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable, cfg_iswrite;
  logic [5:0]  cfg_offset;
  logic [31:0] cfg_write_val;
  logic [3:0]  cfg_be;
  logic [31:0] cfg_read_val;
  logic        cfg_done, cfg_w_err;
  logic        parity_error_detected;
  logic        parity_error_response_reg, serr_enable_reg, mem_space_en;
  logic        bus_master_en, int_disable, msi_enable;
  logic [31:0] bar0_base, msi_addr;
  logic [15:0] msi_data;

  always #5 clk = ~clk;

  pci_cfg_space dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_iswrite(cfg_iswrite),
    .cfg_offset(cfg_offset), .cfg_write_val(cfg_write_val), .cfg_be(cfg_be),
    .cfg_read_val(cfg_read_val), .cfg_done(cfg_done), .cfg_w_err(cfg_w_err),
    .parity_error_detected(parity_error_detected),
    .parity_error_response_reg(parity_error_response_reg),
    .serr_enable_reg(serr_enable_reg), .mem_space_en(mem_space_en),
    .bus_master_en(bus_master_en), .int_disable(int_disable),
    .bar0_base(bar0_base), .msi_enable(msi_enable), .msi_addr(msi_addr),
    .msi_data(msi_data)
  );

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  // Reference model state: one variable per architected field.
  logic [15:0] m_cmd;
  bit          m_perr;
  logic [7:0]  m_cls, m_lat, m_intl;
  logic [31:0] m_bar, m_msi_addr;
  bit          m_msi_en;
  logic [15:0] m_msi_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_cmd = '0; m_perr = 0; m_cls = '0; m_lat = '0; m_intl = '0;
    m_bar = '0; m_msi_addr = '0; m_msi_en = 0; m_msi_data = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] off);
    logic [31:0] v;
    v = 32'h0;
    case (int'(off))
      0, 11: v = {DEV, VEN};
      1: begin
        v[15:0] = m_cmd;
        v[20]   = MSI;
        v[31]   = m_perr;
      end
      2:  v = CLS;
      3:  v = {16'h0, m_lat, m_cls};
      4:  v = m_bar;
      13: v = MSI ? 32'h40 : 32'h0;
      15: v = {16'h0, 8'h01, m_intl};
      16: v = MSI ? {15'h0, m_msi_en, 16'h0005} : 32'h0;
      17: v = MSI ? m_msi_addr : 32'h0;
      18: v = MSI ? {16'h0, m_msi_data} : 32'h0;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_wmask(input logic [5:0] off);
    case (int'(off))
      1:  return 32'h8000_0546;
      3:  return 32'h0000_FFFF;
      4:  return 32'hFFFF_FFFF << BAR_L;
      15: return 32'h0000_00FF;
      16: return MSI ? 32'h0001_0000 : 32'h0;
      17: return MSI ? 32'hFFFF_FFFC : 32'h0;
      18: return MSI ? 32'h0000_FFFF : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [5:0] off, input logic [31:0] wv,
                         input logic [3:0] be, output bit err);
    logic [31:0] mask, old, nv;
    mask = m_wmask(off);
    err  = 0;
    if (mask == 32'h0) begin
      err = (be != 4'hF);
    end else begin
      old = m_read(off);
      nv  = old;
      for (int i = 0; i < 32; i++)
        if (!be[i/8] && mask[i]) nv[i] = wv[i];
      if (off == 6'd1) nv[31] = old[31] & ~(!be[3] & wv[31]);
      case (int'(off))
        1:  begin m_cmd = nv[15:0]; m_perr = nv[31]; end
        3:  begin m_cls = nv[7:0]; m_lat = nv[15:8]; end
        4:  m_bar = nv;
        15: m_intl = nv[7:0];
        16: m_msi_en = nv[16];
        17: m_msi_addr = nv;
        18: m_msi_data = nv[15:0];
        default: ;
      endcase
    end
  endtask

  // One complete handshake; returns what the DUT showed at the first done cycle.
  task automatic access(input bit wr, input logic [5:0] off, input logic [31:0] wv,
                        input logic [3:0] be, input bit coincide,
                        output logic [31:0] rv, output bit err);
    logic [31:0] erd;
    bit eerr, seen;
    int n;
    if (wr) begin
      m_write(off, wv, be, eerr);
      if (coincide) m_perr = 1;
      erd = 32'h0;
    end else begin
      erd  = m_read(off);
      eerr = 0;
    end
    exp_q.push_back({eerr, erd});
    @(negedge clk);
    cfg_iswrite = wr; cfg_offset = off; cfg_write_val = wv; cfg_be = be;
    cfg_enable = 1'b1;
    seen = 0;
    for (n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (cfg_done) begin seen = 1; break; end
      parity_error_detected = (n == 1) && coincide;
    end
    parity_error_detected = 1'b0;
    chk("latency", (seen ? n : 99), 2);
    rv  = cfg_read_val;
    err = cfg_w_err;
    if (!seen) void'(exp_q.pop_back());
    cfg_iswrite = $urandom_range(0, 1); cfg_offset = $urandom_range(0, 63);
    cfg_write_val = $urandom; cfg_be = $urandom_range(0, 15);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    cfg_enable = 1'b0;
    @(negedge clk);
    chk("idle_done", {31'h0, cfg_done}, 32'h0);
    chk("idle_rdval", cfg_read_val, 32'h0);
    chk("idle_werr", {31'h0, cfg_w_err}, 32'h0);
  endtask

  task automatic pulse_parity();
    @(negedge clk);
    parity_error_detected = 1'b1;
    m_perr = 1;
    @(negedge clk);
    parity_error_detected = 1'b0;
  endtask

  task automatic check_mirrors();
    chk("mem_space_en", {31'h0, mem_space_en}, {31'h0, m_cmd[1]});
    chk("bus_master_en", {31'h0, bus_master_en}, {31'h0, m_cmd[2]});
    chk("perr_resp", {31'h0, parity_error_response_reg}, {31'h0, m_cmd[6]});
    chk("serr_en", {31'h0, serr_enable_reg}, {31'h0, m_cmd[8]});
    chk("int_disable", {31'h0, int_disable}, {31'h0, m_cmd[10]});
    chk("bar0_base", bar0_base, m_bar);
    chk("msi_enable", {31'h0, msi_enable}, {31'h0, m_msi_en});
    chk("msi_addr", msi_addr, m_msi_addr);
    chk("msi_data", {16'h0, msi_data}, {16'h0, m_msi_data});
  endtask

  // Monitor: pop on each rising cfg_done and recheck every cycle it holds.
  initial begin
    logic [32:0] cur;
    bit prev;
    cur  = '0;
    prev = 0;
    forever begin
      @(negedge clk);
      if (cfg_done) begin
        if (!prev) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: got done=1 expected no response");
          end else begin
            cur = exp_q.pop_front();
          end
        end
        chk("mon_rdval", cfg_read_val, cur[31:0]);
        chk("mon_werr", {31'h0, cfg_w_err}, {31'h0, cur[32]});
      end
      prev = cfg_done;
    end
  end

  initial begin
    logic [31:0] rv;
    bit err;
    logic [5:0] offs[11];
    offs = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd11, 6'd13, 6'd15, 6'd16, 6'd17, 6'd18};

    rst = 1'b0; cfg_enable = 0; cfg_iswrite = 0; cfg_offset = 0;
    cfg_write_val = 0; cfg_be = 4'hF; parity_error_detected = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_done", {31'h0, cfg_done}, 32'h0);
    chk("rst_rdval", cfg_read_val, 32'h0);
    chk("rst_werr", {31'h0, cfg_w_err}, 32'h0);
    check_mirrors();
    rst = 1'b1;

    // Directed scenarios
    access(0, 6'd0, 32'h0, 4'h0, 0, rv, err);
    chk("id_read", rv, 32'h11E81234);
    chk("id_werr", {31'h0, err}, 32'h0);

    access(1, 6'd1, 32'h0000FFFF, 4'h0, 0, rv, err);
    access(0, 6'd1, 32'h0, 4'h0, 0, rv, err);
    chk("cmd_read", rv, MSI ? 32'h00100546 : 32'h00000546);
    chk("cmd_mirrors", {27'h0, mem_space_en, bus_master_en, parity_error_response_reg,
                        serr_enable_reg, int_disable}, 32'h1F);
    check_mirrors();

    access(1, 6'd4, 32'hFFFFFFFF, 4'h0, 0, rv, err);
    access(0, 6'd4, 32'h0, 4'h0, 0, rv, err);
    chk("bar_size", rv, 32'hFFF00000);
    access(1, 6'd4, 32'hABCDE123, 4'h0, 0, rv, err);
    chk("bar_base", bar0_base, 32'hABC00000);

    pulse_parity();
    access(0, 6'd1, 32'h0, 4'h0, 0, rv, err);
    chk("perr_set", {31'h0, rv[31]}, 32'h1);
    access(1, 6'd1, 32'h80000000, 4'h0, 0, rv, err);
    access(0, 6'd1, 32'h0, 4'h0, 0, rv, err);
    chk("perr_clr", {31'h0, rv[31]}, 32'h0);
    pulse_parity();
    access(1, 6'd1, 32'h80000000, 4'h0, 1, rv, err);
    access(0, 6'd1, 32'h0, 4'h0, 0, rv, err);
    chk("perr_set_wins", {31'h0, rv[31]}, 32'h1);

    access(1, 6'd0, 32'hDEADBEEF, 4'h0, 0, rv, err);
    chk("ro_werr", {31'h0, err}, 32'h1);
    access(0, 6'd0, 32'h0, 4'h0, 0, rv, err);
    chk("ro_unchanged", rv, 32'h11E81234);
    access(1, 6'd15, 32'hFFFF0A0A, 4'hE, 0, rv, err);
    access(0, 6'd15, 32'h0, 4'h0, 0, rv, err);
    chk("int_line", rv, 32'h0000010A);
    check_mirrors();

    // Randomized traffic
    for (int k = 0; k < 250; k++) begin
      logic [5:0] off;
      if ($urandom_range(0, 3) == 0) off = 6'($urandom_range(0, 63));
      else off = offs[$urandom_range(0, 10)];
      if ($urandom_range(0, 9) == 0) pulse_parity();
      access($urandom_range(0, 1), off, $urandom, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 7) == 0) && (off == 6'd1), rv, err);
      check_mirrors();
    end

    // Reset in the middle of a write to offset 3
    access(1, 6'd3, 32'h0000BEEF, 4'h0, 0, rv, err);
    @(negedge clk);
    cfg_iswrite = 1; cfg_offset = 6'd3; cfg_write_val = 32'h00005A5A; cfg_be = 4'h0;
    cfg_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    cfg_enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_done", {31'h0, cfg_done}, 32'h0);
    end
    check_mirrors();
    access(0, 6'd3, 32'h0, 4'h0, 0, rv, err);
    chk("abort_off3", rv, 32'h0);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
